// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MIPS multiply/divide unit controller with HI/LO registers and D-stage stall
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [31:0] p_hi, p_lo;
    logic        p_we;
    logic        launch, commit;

    logic        is_div, is_signed, b_zero;
    logic [63:0] prod;
    logic [31:0] mag_a, mag_b, div_b, uq, ur, q, r;
    logic [31:0] res_hi, res_lo;

    // Result datapath: product or quotient/remainder of the current a/b, evaluated in the start cycle.
    // Signed division works on magnitudes and re-applies signs; this also yields the architected
    // 0x80000000 / -1 result (lo=0x80000000, hi=0) without a special case.
    always_comb begin
        is_div    = op[1];
        is_signed = ~op[0];
        b_zero    = (b == 32'd0);
        if (is_signed)
            prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else
            prod = {32'd0, a} * {32'd0, b};
        mag_a = (is_signed && a[31]) ? (32'd0 - a) : a;
        mag_b = (is_signed && b[31]) ? (32'd0 - b) : b;
        div_b = b_zero ? 32'd1 : mag_b;
        uq    = mag_a / div_b;
        ur    = mag_a % div_b;
        q     = (is_signed && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
        r     = (is_signed && a[31]) ? (32'd0 - ur) : ur;
        if (is_div) begin
            res_hi = r;
            res_lo = q;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    // Next-state logic: launch a timed operation from IDLE, count down in RUN, commit on the last busy cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        launch  = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (start && op <= 3'd3) begin
                    launch  = 1'b1;
                    state_n = RUN;
                    cnt_n   = op[1] ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
                end
            end
            RUN: begin
                cnt_n = cnt - 6'd1;
                if (cnt <= 6'd1) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                    cnt_n   = 6'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy  = (state == RUN);
    assign stall = d_md & (busy | (start & (op <= 3'd3)));

    // State and latency counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Pending result captured at launch; a zero divisor suppresses the eventual write.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_hi <= 32'd0;
            p_lo <= 32'd0;
            p_we <= 1'b0;
        end else if (launch) begin
            p_hi <= res_hi;
            p_lo <= res_lo;
            p_we <= ~(is_div & b_zero);
        end
    end

    // Architectural HI/LO: written only by a commit or by MTHI/MTLO accepted in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            if (p_we) begin
                hi <= p_hi;
                lo <= p_lo;
            end
        end else if (state == IDLE && start) begin
            if (op == 3'd4) hi <= a;
            if (op == 3'd5) lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard testbench for mdu_ctrl
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        d_md;
    logic        busy, stall;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .d_md(d_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: on every non-reset busy falling edge, pop and compare hi/lo and busy length
    logic prev_busy = 1'b0;
    logic prev_reset = 1'b1;
    int   run_len = 0;
    always @(negedge clk) begin
        if (prev_busy === 1'b1 && busy === 1'b0) begin
            if (prev_reset === 1'b1) begin
                run_len = 0;
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_commit: got hi=%h lo=%h expected no operation", hi, lo);
                run_len = 0;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_hi", hi, e.hi);
                chk("commit_lo", lo, e.lo);
                chk("busy_len", 32'(run_len), 32'(e.len));
                run_len = 0;
            end
        end
        if (busy === 1'b1) run_len++;
        prev_busy  = busy;
        prev_reset = reset;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
        exp_t e;
        e.hi = h; e.lo = l; e.len = n;
        exp_q.push_back(e);
    endtask

    // Present one request for one cycle; on return we are #1 after the accepting edge
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        cyc(1);
        start = 1'b0; op = 3'd7;
    endtask

    // Wait (bounded) until busy drops; returns at the negedge of the first idle cycle
    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin done = 1; break; end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got busy stuck expected idle", name);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd7; a = 0; b = 0; d_md = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(10);
        @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall_d0", 32'(stall), 32'd0);
        d_md = 1'b1;
        #1 chk("rst_stall_d1", 32'(stall), 32'd0);
        d_md = 1'b0;
        cyc(1);

        // multiplies and divides with hand-computed results
        push(32'hFFFFFFFF, 32'hFFFFFFFA, 5); issue(3'd0, 32'hFFFFFFFE, 32'd3); wait_idle("mult");
        push(32'h00000002, 32'hFFFFFFFA, 5); issue(3'd1, 32'hFFFFFFFE, 32'd3); wait_idle("multu");
        push(32'h40000000, 32'h00000000, 5); issue(3'd0, 32'h80000000, 32'h80000000); wait_idle("mult_min");
        push(32'hFFFFFFFE, 32'h00000001, 5); issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle("multu_max");
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10); issue(3'd2, 32'hFFFFFFF9, 32'd2); wait_idle("div_neg");
        push(32'h00000001, 32'hFFFFFFFD, 10); issue(3'd2, 32'd7, 32'hFFFFFFFE); wait_idle("div_negb");
        push(32'h00000001, 32'h00000003, 10); issue(3'd3, 32'd7, 32'd2); wait_idle("divu");
        push(32'h00000000, 32'h80000000, 10); issue(3'd2, 32'h80000000, 32'hFFFFFFFF); wait_idle("div_ovf");

        // stall with d_md held, then back-to-back start in the first idle cycle
        cyc(1);
        d_md = 1'b1; start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        push(32'd2, 32'd14, 10);
        @(negedge clk);
        chk("stall_k", 32'(stall), 32'd1);
        cyc(1);
        start = 1'b0; op = 3'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("stall_k%0d", i), 32'(stall), 32'd1);
        end
        @(negedge clk);
        chk("stall_k11", 32'(stall), 32'd0);
        chk("busy_k11", 32'(busy), 32'd0);
        start = 1'b1; op = 3'd3; a = 32'hFFFFFFFF; b = 32'h10;
        push(32'h0000000F, 32'h0FFFFFFF, 10);
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7; d_md = 1'b0;
        @(negedge clk);
        chk("busy_k12", 32'(busy), 32'd1);
        wait_idle("b2b");
        cyc(1);

        // MTHI/MTLO then divide by zero leaves hi/lo untouched
        issue(3'd4, 32'h11111111, 32'd0);
        @(negedge clk);
        chk("mthi_hi", hi, 32'h11111111);
        chk("mthi_busy", 32'(busy), 32'd0);
        cyc(1);
        issue(3'd5, 32'h22222222, 32'd0);
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h22222222);
        chk("mtlo_hi", hi, 32'h11111111);
        cyc(1);
        push(32'h11111111, 32'h22222222, 10); issue(3'd2, 32'd5, 32'd0); wait_idle("div0");
        cyc(1);

        // op 6 is a no-op
        issue(3'd6, 32'hDEADBEEF, 32'd1);
        @(negedge clk);
        chk("nop_busy", 32'(busy), 32'd0);
        chk("nop_hi", hi, 32'h11111111);
        chk("nop_lo", lo, 32'h22222222);
        cyc(1);

        // reset in the middle of a MULT discards it
        issue(3'd0, 32'd4, 32'd5);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        cyc(10);
        @(negedge clk);
        chk("midrst_hi_later", hi, 32'h0);
        chk("midrst_lo_later", lo, 32'h0);
        cyc(1);
        push(32'd0, 32'd20, 5); issue(3'd0, 32'd4, 32'd5); wait_idle("mult_after_rst");

        cyc(3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the EX stage and runs multi-cycle operations with a fixed-latency counter. It holds the architectural HI/LO registers and generates the stall that keeps a following MD-class instruction in the D stage until HI/LO are valid.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; clears all state
- start  in  1  EX stage holds a valid MD-class instruction this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- a  in  32  rs operand (forwarded value)
- b  in  32  rt operand (forwarded value)
- d_md  in  1  D stage holds MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
- busy  out  1  operation in progress
- stall  out  1  freeze PC and F/D, bubble D/E
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. 6-bit down counter `cnt`. Pending registers `p_hi`/`p_lo` and a pending-write-enable flag.
- IDLE, start, op∈{0..3}: compute the result from a/b in the same cycle and latch it into p_hi/p_lo. Load cnt with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- RUN: decrement cnt each cycle. When cnt==1, commit p_hi/p_lo to hi/lo and return to IDLE.
- MULT: signed 64-bit product, {hi,lo} = a*b. MULTU: the same, unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend. DIVU: unsigned quotient/remainder.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): lo = 0x80000000, hi = 0.
- Divide by zero (b==0, DIV/DIVU): runs the full DIV_CYCLES. hi/lo keep their previous values (pending write suppressed).
- MTHI/MTLO with start in IDLE: write a into hi/lo at the next edge. No RUN state, busy stays 0.
- start while in RUN: ignored. This is a protocol violation that stall makes impossible.
- op 6/7 with start: ignored.
- stall = d_md & (busy | (start & op≤3)). Combinational, no registered delay.
- Reset, including mid-RUN: state=IDLE, cnt=0, busy=0, hi=0, lo=0. The pending result is discarded.

## Timing
- Reset values: busy=0, stall=0 (given d_md=0), hi=0, lo=0.
- Start sampled at edge k (op≤3):
  - busy=1 during cycles k+1 … k+N (N = MULT_CYCLES or DIV_CYCLES).
  - hi/lo update at edge k+N.
  - busy=0 from cycle k+N+1 onward.
  - An MFHI in D is released in cycle k+N+1 and reads the new value.
- stall is asserted in cycle k itself if d_md=1, then in every busy cycle with d_md=1.
- Back-to-back operations: a new start is accepted in the first cycle busy=0. There is no dead cycle.
- MTHI/MTLO latency: 1 edge; the value is visible in the next cycle.
- hi/lo never change except at a commit edge, an MTHI/MTLO edge, or reset.

## Test plan
- Reset then idle: after 10 cycles, hi=0, lo=0, busy=0, stall=0 for any d_md.
- MULT a=0xFFFFFFFE (-2), b=3 at edge k: busy high for exactly 5 cycles. At k+5, hi=0xFFFFFFFF and lo=0xFFFFFFFA. MULTU with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2: after 10 cycles, lo=0xFFFFFFFD and hi=0xFFFFFFFF. DIVU a=7, b=2 gives lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- Stall: start DIV with d_md=1 held. stall=1 in cycles k … k+10 and 0 at k+11. A second start in cycle k+11 sets busy again at k+12.
- Divide by zero: preload hi=0x11111111 via MTHI and lo=0x22222222 via MTLO. DIV a=5, b=0 keeps busy for 10 cycles, then hi/lo are unchanged. MTHI takes effect after 1 cycle with busy=0.
- Reset asserted at cycle k+3 of MULT 4×5: at the next edge, busy=0 and hi=lo=0. No commit ever appears, and a fresh MULT afterwards gives lo=20.
